// File: rtl/thumb_fetch_unit_if.sv
// Fetch-unit bundle: instruction-memory read port, decode-side handshake, branch redirect.
interface thumb_fetch_unit_if #(parameter int ADDR_W = 10);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
  logic              inst_valid;
  logic              inst_ready;
  logic [15:0]       inst_data;
  logic [31:0]       inst_pc;
  logic              redirect;
  logic [31:0]       redirect_pc;

  modport master (
    output mem_req, mem_addr, inst_valid, inst_data, inst_pc,
    input  mem_ack, mem_rdata, inst_ready, redirect, redirect_pc
  );

  modport slave (
    input  mem_req, mem_addr, inst_valid, inst_data, inst_pc,
    output mem_ack, mem_rdata, inst_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/thumb_fetch_unit.sv
// Thumb fetch stage: word reads split into halfwords, queued for decode with their byte PC.
// A redirect flushes the queue; a read already in flight is drained and its data dropped.
module thumb_fetch_unit #(
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          QDEPTH   = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  thumb_fetch_unit_if.master bus
);
  localparam int PW    = ADDR_W + 2;
  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = $clog2(QDEPTH + 1);
  localparam logic [CNT_W:0] ROOM_MAX = (CNT_W+1)'(QDEPTH - 2);
  localparam logic [CNT_W:0] ONE      = (CNT_W+1)'(1);
  localparam logic [CNT_W:0] TWO      = (CNT_W+1)'(2);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;
  typedef struct packed {
    logic [15:0]   data;
    logic [PW-1:0] pc;
  } qent_t;

  state_t            state;
  logic [PW-1:1]     fetch_pc;
  logic              mem_req_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              inst_valid_q;
  qent_t             q [QDEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr, wr_ptr1;
  logic [CNT_W-1:0]  count;
  logic              pop, take, room;
  logic [CNT_W:0]    npush, cnt_after;
  logic [ADDR_W-1:0] cur_word, nxt_word;
  logic              unused_redirect_bits;

  assign cur_word  = fetch_pc[PW-1:2];
  assign nxt_word  = cur_word + 1'b1;
  assign wr_ptr1   = wr_ptr + 1'b1;
  assign pop       = inst_valid_q & bus.inst_ready;
  assign take      = (state == REQ) & bus.mem_ack & ~bus.redirect;
  assign npush     = !take ? '0 : (fetch_pc[1] ? ONE : TWO);
  assign cnt_after = {1'b0, count} - {{CNT_W{1'b0}}, pop} + npush;
  // A new read is only launched when a full word fits after this cycle's push/pop
  assign room      = cnt_after <= ROOM_MAX;

  assign unused_redirect_bits = ^{bus.redirect_pc[31:PW], bus.redirect_pc[0]};

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.inst_valid = inst_valid_q;
  assign bus.inst_data  = q[rd_ptr].data;
  assign bus.inst_pc    = {{(32-PW){1'b0}}, q[rd_ptr].pc};

  always_ff @(posedge clock) begin
    if (take) begin
      if (fetch_pc[1]) begin
        q[wr_ptr] <= '{data: bus.mem_rdata[31:16], pc: {cur_word, 2'b10}};
      end else begin
        q[wr_ptr]  <= '{data: bus.mem_rdata[15:0],  pc: {cur_word, 2'b00}};
        q[wr_ptr1] <= '{data: bus.mem_rdata[31:16], pc: {cur_word, 2'b10}};
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state        <= IDLE;
      mem_req_q    <= 1'b0;
      inst_valid_q <= 1'b0;
      count        <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      fetch_pc     <= RESET_PC[PW-1:1];
    end else if (bus.redirect) begin
      count        <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      inst_valid_q <= 1'b0;
      fetch_pc     <= bus.redirect_pc[PW-1:1];
      case (state)
        // Nothing in flight: launch the target read straight away for 2-cycle redirect latency
        IDLE: begin
          state      <= REQ;
          mem_req_q  <= 1'b1;
          mem_addr_q <= bus.redirect_pc[PW-1:2];
        end
        REQ, DRAIN: begin
          if (bus.mem_ack) begin
            state     <= IDLE;
            mem_req_q <= 1'b0;
          end else begin
            state <= DRAIN;
          end
        end
        default: begin
          state     <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end else begin
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (take) wr_ptr <= wr_ptr + npush[PTR_W-1:0];
      count        <= cnt_after[CNT_W-1:0];
      inst_valid_q <= cnt_after != '0;
      case (state)
        IDLE: begin
          if (room) begin
            state      <= REQ;
            mem_req_q  <= 1'b1;
            mem_addr_q <= cur_word;
          end
        end
        REQ: begin
          if (bus.mem_ack) begin
            fetch_pc <= {nxt_word, 1'b0};
            if (room) begin
              mem_addr_q <= nxt_word;
            end else begin
              state     <= IDLE;
              mem_req_q <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (bus.mem_ack) begin
            state     <= IDLE;
            mem_req_q <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_thumb_fetch_unit.sv
// Directed bench for thumb_fetch_unit: word memory with programmable ack latency,
// checks sampled on the falling edge, inputs driven on the falling edge.
module tb_thumb_fetch_unit;
  localparam int ADDR_W = 10;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  thumb_fetch_unit_if #(.ADDR_W(ADDR_W)) bus();

  thumb_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(32'h0), .QDEPTH(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Memory model: ack after lat extra cycles of mem_req being high (lat=0 is zero-wait)
  logic [31:0] mem [1024];
  logic [3:0]  lat = 4'd0;
  logic [3:0]  wait_cnt = 4'd0;
  assign bus.mem_ack   = bus.mem_req && (wait_cnt == lat);
  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clock) begin
    if (!bus.mem_req || bus.mem_ack) wait_cnt <= 4'd0;
    else                             wait_cnt <= wait_cnt + 4'd1;
  end

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  task automatic head(input string tag, input logic [15:0] d, input logic [31:0] pc);
    chk({tag, "_v"},  32'(bus.inst_valid), 32'd1);
    chk({tag, "_d"},  32'(bus.inst_data), 32'(d));
    chk({tag, "_pc"}, bus.inst_pc, pc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 1024; i++) mem[i] = {16'hB000 + 16'(i), 16'hA000 + 16'(i)};
    mem[0] = 32'h11112222;
    mem[1] = 32'h33334444;
    bus.inst_ready  = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;

    // Reset state
    tick(2);
    chk("rst_req", 32'(bus.mem_req), 32'd0);
    chk("rst_vld", 32'(bus.inst_valid), 32'd0);

    // Zero-wait streaming from RESET_PC
    reset_n = 1'b1;
    tick();
    chk("t1_req", 32'(bus.mem_req), 32'd1);
    chk("t1_addr", 32'(bus.mem_addr), 32'd0);
    chk("t1_vld0", 32'(bus.inst_valid), 32'd0);
    tick(); head("t1_h0", 16'h2222, 32'h0);
    tick(); head("t1_h1", 16'h1111, 32'h2);
    tick(); head("t1_h2", 16'h4444, 32'h4);
    tick(); head("t1_h3", 16'h3333, 32'h6);

    // Backpressure: queue fills, fetch stops, head holds, then resumes losslessly
    reset_n = 1'b0;
    bus.inst_ready = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(3);
    chk("t2_stop", 32'(bus.mem_req), 32'd0);
    head("t2_hold0", 16'h2222, 32'h0);
    tick(3);
    chk("t2_still", 32'(bus.mem_req), 32'd0);
    head("t2_hold1", 16'h2222, 32'h0);
    bus.inst_ready = 1'b1;
    tick(); head("t2_r1", 16'h1111, 32'h2);
    tick(); head("t2_r2", 16'h4444, 32'h4);
    tick(); head("t2_r3", 16'h3333, 32'h6);
    tick(); head("t2_r4", 16'hA002, 32'h8);
    tick(); head("t2_r5", 16'hB002, 32'hA);
    tick(); head("t2_r6", 16'hA003, 32'hC);

    // Redirect to an odd halfword while IDLE (queue full, pop coincides with redirect)
    bus.inst_ready = 1'b0;
    tick(6);
    chk("t3_idle", 32'(bus.mem_req), 32'd0);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000000E;
    bus.inst_ready  = 1'b1;
    tick();
    bus.redirect = 1'b0;
    chk("t3_req", 32'(bus.mem_req), 32'd1);
    chk("t3_addr", 32'(bus.mem_addr), 32'd3);
    chk("t3_flush", 32'(bus.inst_valid), 32'd0);
    tick(); head("t3_h0", 16'hB003, 32'hE);
    tick(); head("t3_h1", 16'hA004, 32'h10);
    tick(); head("t3_h2", 16'hB004, 32'h12);

    // 3-cycle memory, redirect in the first cycle of the read to word 1
    reset_n = 1'b0;
    lat = 4'd2;
    bus.inst_ready = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(4);
    chk("t4_addr1", 32'(bus.mem_addr), 32'd1);
    chk("t4_noack", 32'(bus.mem_ack), 32'd0);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h00000020;
    tick();
    bus.redirect = 1'b0;
    chk("t4_drain_req", 32'(bus.mem_req), 32'd1);
    chk("t4_drain_addr", 32'(bus.mem_addr), 32'd1);
    chk("t4_flush", 32'(bus.inst_valid), 32'd0);
    tick();
    chk("t4_ack_addr", 32'(bus.mem_addr), 32'd1);
    chk("t4_ack", 32'(bus.mem_ack), 32'd1);
    tick();
    chk("t4_idle", 32'(bus.mem_req), 32'd0);
    chk("t4_drop", 32'(bus.inst_valid), 32'd0);
    tick();
    chk("t4_req8", 32'(bus.mem_req), 32'd1);
    chk("t4_addr8", 32'(bus.mem_addr), 32'd8);
    n = 0;
    while (bus.inst_valid !== 1'b1 && n < 12) begin tick(); n++; end
    head("t4_first", 16'hA008, 32'h20);

    // Redirect coincident with ack, then reset in the middle of a drain
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(3);
    chk("t5_ack", 32'(bus.mem_ack), 32'd1);
    chk("t5_ack_addr", 32'(bus.mem_addr), 32'd0);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h00000040;
    tick();
    bus.redirect = 1'b0;
    chk("t5_req_off", 32'(bus.mem_req), 32'd0);
    chk("t5_drop", 32'(bus.inst_valid), 32'd0);
    tick();
    chk("t5_req16", 32'(bus.mem_req), 32'd1);
    chk("t5_addr16", 32'(bus.mem_addr), 32'd16);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h00000080;
    tick();
    bus.redirect = 1'b0;
    reset_n = 1'b0;
    chk("t5_drain_req", 32'(bus.mem_req), 32'd1);
    chk("t5_drain_addr", 32'(bus.mem_addr), 32'd16);
    tick();
    chk("t5_rst_req", 32'(bus.mem_req), 32'd0);
    chk("t5_rst_vld", 32'(bus.inst_valid), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("t5_restart_req", 32'(bus.mem_req), 32'd1);
    chk("t5_restart_addr", 32'(bus.mem_addr), 32'd0);
    n = 0;
    while (bus.inst_valid !== 1'b1 && n < 12) begin tick(); n++; end
    head("t5_first", 16'h2222, 32'h0);

    // Top-of-memory wrap
    reset_n = 1'b0;
    lat = 4'd0;
    tick(2);
    reset_n = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h00000FFC;
    tick();
    bus.redirect   = 1'b0;
    bus.inst_ready = 1'b1;
    chk("t6_req", 32'(bus.mem_req), 32'd1);
    chk("t6_addr_top", 32'(bus.mem_addr), 32'd1023);
    tick();
    chk("t6_addr_wrap", 32'(bus.mem_addr), 32'd0);
    head("t6_h0", 16'hA3FF, 32'hFFC);
    tick(); head("t6_h1", 16'hB3FF, 32'hFFE);
    tick(); head("t6_h2", 16'h2222, 32'h0);
    tick(); head("t6_h3", 16'h1111, 32'h2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
